// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 INCR-burst responder over a 64-bit word array with
// configurable read latency, byte strobes and DECERR/SLVERR reporting.
module axi_sram_slave #(
  parameter int          DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          READ_LAT  = 2,
  parameter string       INIT_FILE = ""
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        ARVALID,
  output logic        ARREADY,
  input  logic [31:0] ARADDR,
  input  logic [7:0]  ARLEN,
  input  logic [2:0]  ARPROT,
  output logic        RVALID,
  input  logic        RREADY,
  output logic [63:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] AWADDR,
  input  logic [7:0]  AWLEN,
  input  logic [2:0]  AWPROT,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [63:0] WDATA,
  input  logic [7:0]  WSTRB,
  input  logic        WLAST,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [1:0]  BRESP
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  logic [63:0] mem [DEPTH];
  logic unused_prot;
  assign unused_prot = ^{ARPROT, AWPROT};
  r_state_e    r_state_q, r_state_d;
  logic [31:0] r_base_q, r_base_d, r_idx;
  logic [7:0]  r_len_q, r_len_d, r_beat_q, r_beat_d, r_next;
  logic [3:0]  r_lat_q, r_lat_d;
  logic        ar_ready_q, ar_ready_d, r_valid_q, r_valid_d, r_last_q, r_last_d, r_in;
  logic [1:0]  r_resp_q, r_resp_d;
  logic [63:0] r_data_q, r_data_d;
  // Word index is 32 bits wide so bursts past the top fall out of range instead of wrapping.
  assign r_next = (r_state_q == R_DATA) ? r_beat_q + 8'd1 : 8'd0;
  assign r_idx  = r_base_q + {24'd0, r_next};
  assign r_in   = r_idx < 32'(DEPTH);
  always_comb begin
    r_state_d  = r_state_q;
    r_base_d   = r_base_q;
    r_len_d    = r_len_q;
    r_beat_d   = r_beat_q;
    r_lat_d    = r_lat_q;
    ar_ready_d = ar_ready_q;
    r_valid_d  = r_valid_q;
    r_last_d   = r_last_q;
    r_resp_d   = r_resp_q;
    r_data_d   = r_data_q;
    case (r_state_q)
      R_IDLE: begin
        ar_ready_d = 1'b1;
        if (ARVALID && ar_ready_q) begin
          r_base_d   = (ARADDR - BASE_ADDR) >> 3;
          r_len_d    = ARLEN;
          r_lat_d    = 4'(READ_LAT - 1);
          ar_ready_d = 1'b0;
          r_state_d  = R_WAIT;
        end
      end
      R_WAIT: begin
        r_lat_d = r_lat_q - 4'd1;
        if (r_lat_q == 4'd0) begin
          r_valid_d = 1'b1;
          r_beat_d  = r_next;
          r_last_d  = r_next == r_len_q;
          r_resp_d  = r_in ? 2'b00 : 2'b11;
          r_data_d  = r_in ? mem[r_idx[AW-1:0]] : 64'd0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (RREADY && r_last_q) begin
          r_valid_d  = 1'b0;
          r_last_d   = 1'b0;
          ar_ready_d = 1'b1;
          r_state_d  = R_IDLE;
        end else if (RREADY) begin
          r_beat_d = r_next;
          r_last_d = r_next == r_len_q;
          r_resp_d = r_in ? 2'b00 : 2'b11;
          r_data_d = r_in ? mem[r_idx[AW-1:0]] : 64'd0;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q  <= R_IDLE;
      r_base_q   <= '0;
      r_len_q    <= '0;
      r_beat_q   <= '0;
      r_lat_q    <= '0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_resp_q   <= '0;
      r_data_q   <= '0;
    end else begin
      r_state_q  <= r_state_d;
      r_base_q   <= r_base_d;
      r_len_q    <= r_len_d;
      r_beat_q   <= r_beat_d;
      r_lat_q    <= r_lat_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_last_q   <= r_last_d;
      r_resp_q   <= r_resp_d;
      r_data_q   <= r_data_d;
    end
  end
  assign ARREADY = ar_ready_q;
  assign RVALID  = r_valid_q;
  assign RLAST   = r_last_q;
  assign RRESP   = r_resp_q;
  assign RDATA   = r_data_q;
  w_state_e    w_state_q, w_state_d;
  logic [31:0] w_base_q, w_base_d, w_idx;
  logic [7:0]  w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic        aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, b_valid_q, b_valid_d;
  logic        w_fire, w_in, w_end;
  logic [1:0]  w_err_q, w_err_d, w_err_n, b_resp_q, b_resp_d;
  assign w_fire  = WVALID && w_ready_q;
  assign w_idx   = w_base_q + {24'd0, w_cnt_q};
  assign w_in    = w_idx < 32'(DEPTH);
  assign w_end   = w_cnt_q == w_len_q;
  // DECERR outranks SLVERR once recorded.
  assign w_err_n = !w_in ? 2'b11 : (WLAST != w_end && w_err_q != 2'b11) ? 2'b10 : w_err_q;
  always_comb begin
    w_state_d  = w_state_q;
    w_base_d   = w_base_q;
    w_len_d    = w_len_q;
    w_cnt_d    = w_cnt_q;
    w_err_d    = w_err_q;
    aw_ready_d = aw_ready_q;
    w_ready_d  = w_ready_q;
    b_valid_d  = b_valid_q;
    b_resp_d   = b_resp_q;
    case (w_state_q)
      W_IDLE: begin
        aw_ready_d = 1'b1;
        w_ready_d  = 1'b0;
        if (AWVALID && aw_ready_q) begin
          w_base_d   = (AWADDR - BASE_ADDR) >> 3;
          w_len_d    = AWLEN;
          w_cnt_d    = 8'd0;
          w_err_d    = 2'b00;
          aw_ready_d = 1'b0;
          w_ready_d  = 1'b1;
          w_state_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (w_fire) begin
          w_err_d = w_err_n;
          w_cnt_d = w_cnt_q + 8'd1;
          if (w_end) begin
            w_ready_d = 1'b0;
            b_valid_d = 1'b1;
            b_resp_d  = w_err_n;
            w_state_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (BREADY) begin
          b_valid_d  = 1'b0;
          aw_ready_d = 1'b1;
          w_state_d  = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q  <= W_IDLE;
      w_base_q   <= '0;
      w_len_q    <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= '0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= '0;
    end else begin
      w_state_q  <= w_state_d;
      w_base_q   <= w_base_d;
      w_len_q    <= w_len_d;
      w_cnt_q    <= w_cnt_d;
      w_err_q    <= w_err_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
    end
  end
  // Array is never reset; reads above sample it before this edge's write lands.
  always_ff @(posedge ACLK) begin
    if (w_fire && w_in)
      for (int i = 0; i < 8; i++)
        if (WSTRB[i]) mem[w_idx[AW-1:0]][8*i +: 8] <= WDATA[8*i +: 8];
  end
  assign AWREADY = aw_ready_q;
  assign WREADY  = w_ready_q;
  assign BVALID  = b_valid_q;
  assign BRESP   = b_resp_q;
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: randomized AXI traffic against a sparse word-array reference model.
module tb_axi_sram_slave;
  localparam int          DEPTH    = 4096;
  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam int          READ_LAT = 2;
  logic        ACLK = 0, ARESETn = 0;
  logic        ARVALID = 0, ARREADY, RVALID, RREADY = 0, RLAST;
  logic [31:0] ARADDR = 0, AWADDR = 0;
  logic [7:0]  ARLEN = 0, AWLEN = 0, WSTRB = 0;
  logic [2:0]  ARPROT = 0, AWPROT = 0;
  logic [63:0] RDATA, WDATA = 0;
  logic [1:0]  RRESP, BRESP;
  logic        AWVALID = 0, AWREADY, WVALID = 0, WREADY, WLAST = 0, BVALID, BREADY = 0;
  int checks = 0, errors = 0;
  logic [63:0] ref_mem [logic [31:0]];
  axi_sram_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LAT(READ_LAT), .INIT_FILE("")) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );
  always #5 ACLK = ~ACLK;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask
  function automatic logic [31:0] word_of(input logic [31:0] a, input int k);
    return ((a - BASE) >> 3) + 32'(k);
  endfunction
  task automatic rd(input logic [31:0] a, input logic [7:0] len, input int mode);
    int n, beat, ph;
    bit fire;
    logic [31:0] idx;
    ARADDR = a; ARLEN = len; ARVALID = 1; ARPROT = 3'($urandom);
    n = 0;
    while (!ARREADY && n < 100) begin tick(); n++; end
    tick();
    ARVALID = 0;
    n = 0;
    while (!RVALID && n < 40) begin tick(); n++; end
    check("r_latency", 64'(n), 64'(READ_LAT));
    beat = 0; ph = 0; n = 0;
    while (beat <= int'(len) && n < 3000) begin
      fire = 0;
      if (RVALID) begin
        idx = word_of(a, beat);
        check("r_resp", 64'(RRESP), (idx < DEPTH) ? 64'd0 : 64'd3);
        check("r_last", 64'(RLAST), 64'(beat == int'(len)));
        if (idx >= DEPTH) check("r_data_oor", RDATA, 64'd0);
        else if (ref_mem.exists(idx)) check("r_data", RDATA, ref_mem[idx]);
        RREADY = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(ph % 2 == 0) : 1'($urandom_range(2) != 0);
        fire = RREADY;
        ph++;
      end else RREADY = 0;
      tick(); n++;
      if (fire) beat++;
    end
    RREADY = 0;
    check("r_beats", 64'(beat), 64'(int'(len) + 1));
    check("r_valid_done", 64'(RVALID), 64'd0);
    check("ar_ready_done", 64'(ARREADY), 64'd1);
  endtask
  task automatic wr(input logic [31:0] a, input logic [7:0] len, input logic [63:0] d0,
                    input logic [7:0] s0, input int wl, input bit rs);
    int n, beat;
    bit oor, fire;
    logic [31:0] idx;
    logic [63:0] t;
    logic [1:0] eb;
    oor = 0;
    for (int k = 0; k <= int'(len); k++) if (word_of(a, k) >= DEPTH) oor = 1;
    eb = oor ? 2'd3 : (wl != int'(len)) ? 2'd2 : 2'd0;
    AWADDR = a; AWLEN = len; AWVALID = 1; AWPROT = 3'($urandom);
    WDATA = d0; WSTRB = s0; WLAST = (wl == 0); WVALID = 1;
    check("w_ready_before_aw", 64'(WREADY), 64'd0);
    n = 0;
    while (!AWREADY && n < 100) begin tick(); n++; end
    tick();
    AWVALID = 0;
    beat = 0; n = 0;
    while (beat <= int'(len) && n < 3000) begin
      fire = WVALID && WREADY;
      idx = word_of(a, beat);
      if (fire && idx < DEPTH) begin
        if (ref_mem.exists(idx)) begin
          t = ref_mem[idx];
          for (int b = 0; b < 8; b++) if (WSTRB[b]) t[8*b +: 8] = WDATA[8*b +: 8];
          ref_mem[idx] = t;
        end else if (WSTRB == 8'hFF) ref_mem[idx] = WDATA;
      end
      tick(); n++;
      if (fire) begin
        beat++;
        WDATA = {$urandom, $urandom};
        WSTRB = rs ? 8'($urandom) : 8'hFF;
        WLAST = (beat == wl);
        WVALID = (beat <= int'(len)) && ($urandom_range(3) != 0);
      end else if (beat <= int'(len)) WVALID = 1;
    end
    WVALID = 0; WLAST = 0;
    check("w_beats", 64'(beat), 64'(int'(len) + 1));
    check("w_ready_done", 64'(WREADY), 64'd0);
    check("b_valid", 64'(BVALID), 64'd1);
    check("b_resp", 64'(BRESP), 64'(eb));
    n = $urandom_range(3);
    for (int i = 0; i < n; i++) tick();
    check("b_resp_hold", 64'(BRESP), 64'(eb));
    BREADY = 1;
    tick();
    BREADY = 0;
    check("b_valid_done", 64'(BVALID), 64'd0);
    check("aw_ready_done", 64'(AWREADY), 64'd1);
  endtask
  initial begin
    int n, beat, len, sel, wl;
    logic [31:0] a;
    logic [63:0] old_w, new_w;
    bit fire;
    for (int i = 0; i < 3; i++) tick();
    check("rst_arready", 64'(ARREADY), 64'd0);
    check("rst_awready", 64'(AWREADY), 64'd0);
    check("rst_rvalid", 64'(RVALID), 64'd0);
    check("rst_rlast", 64'(RLAST), 64'd0);
    check("rst_rresp", 64'(RRESP), 64'd0);
    check("rst_rdata", RDATA, 64'd0);
    check("rst_wready", 64'(WREADY), 64'd0);
    check("rst_bvalid", 64'(BVALID), 64'd0);
    check("rst_bresp", 64'(BRESP), 64'd0);
    ARESETn = 1;
    #1;
    check("rel_arready_pre", 64'(ARREADY), 64'd0);
    tick();
    check("rel_arready", 64'(ARREADY), 64'd1);
    check("rel_awready", 64'(AWREADY), 64'd1);
    for (int i = 0; i < 4; i++) wr(BASE + 32'(i * 128), 8'd15, {$urandom, $urandom}, 8'hFF, 15, 0);
    wr(BASE, 8'd0, 64'h1122334455667788, 8'hFF, 0, 0);
    rd(BASE, 8'd0, 0);
    rd(BASE + 32'h10, 8'd3, 1);
    wr(BASE + 32'h8, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0);
    wr(BASE + 32'h8, 8'd0, 64'hAAAA_BBBB_CCCC_DDDD, 8'h0F, 0, 0);
    rd(BASE + 32'h8, 8'd0, 0);
    rd(BASE + 32'(DEPTH * 8), 8'd0, 0);
    wr(BASE + 32'((DEPTH - 1) * 8), 8'd1, {$urandom, $urandom}, 8'hFF, 1, 0);
    rd(BASE + 32'((DEPTH - 1) * 8), 8'd1, 2);
    wr(BASE + 32'(20 * 8), 8'd2, {$urandom, $urandom}, 8'hFF, 1, 0);
    rd(BASE + 32'(20 * 8), 8'd2, 0);
    old_w = ref_mem[32'd10];
    new_w = {$urandom, $urandom};
    AWADDR = BASE + 32'(10 * 8); AWLEN = 0; AWVALID = 1;
    tick();
    AWVALID = 0;
    ARADDR = BASE + 32'(10 * 8); ARLEN = 0; ARVALID = 1;
    tick();
    ARVALID = 0;
    for (int i = 0; i < READ_LAT - 1; i++) tick();
    WDATA = new_w; WSTRB = 8'hFF; WLAST = 1; WVALID = 1;
    tick();
    WVALID = 0; WLAST = 0;
    check("coll_rvalid", 64'(RVALID), 64'd1);
    check("coll_old_data", RDATA, old_w);
    RREADY = 1;
    tick();
    RREADY = 0;
    check("coll_bvalid", 64'(BVALID), 64'd1);
    check("coll_bresp", 64'(BRESP), 64'd0);
    BREADY = 1;
    tick();
    BREADY = 0;
    ref_mem[32'd10] = new_w;
    rd(BASE + 32'(10 * 8), 8'd0, 0);
    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(9);
      len = $urandom_range(7);
      a = (sel < 8) ? BASE + 32'($urandom_range(63) * 8) :
          (sel == 8) ? BASE + 32'((DEPTH - 4 + $urandom_range(6)) * 8) :
          BASE - 32'($urandom_range(4, 1) * 8);
      a = a + 32'($urandom_range(7));
      if ($urandom_range(1) == 0) rd(a, 8'(len), 2);
      else begin
        wl = ($urandom_range(4) == 0) ? $urandom_range(len) : len;
        wr(a, 8'(len), {$urandom, $urandom}, 8'($urandom), wl, 1);
      end
    end
    ARADDR = BASE; ARLEN = 7; ARVALID = 1;
    n = 0;
    while (!ARREADY && n < 100) begin tick(); n++; end
    tick();
    ARVALID = 0;
    RREADY = 1;
    beat = 0; n = 0;
    while (beat < 2 && n < 100) begin
      fire = RVALID;
      tick(); n++;
      if (fire) beat++;
    end
    check("mid_rvalid_pre", 64'(RVALID), 64'd1);
    ARESETn = 0;
    #1;
    check("mid_rvalid_async", 64'(RVALID), 64'd0);
    check("mid_rlast_async", 64'(RLAST), 64'd0);
    check("mid_arready_async", 64'(ARREADY), 64'd0);
    RREADY = 0;
    tick();
    tick();
    ARESETn = 1;
    #1;
    check("mid_arready_pre", 64'(ARREADY), 64'd0);
    tick();
    check("mid_arready_rel", 64'(ARREADY), 64'd1);
    check("mid_awready_rel", 64'(AWREADY), 64'd1);
    rd(BASE, 8'd7, 2);
    rd(BASE + 32'(20 * 8), 8'd2, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
